// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// The optional FETCH_PERF_EN build enables the decode-starve counter in fetch_queue.
package fetch_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INST    = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries with separate alloc (tail), fill and pop (head) pointers.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         alloc_i,
    input  logic [31:0]  alloc_pc_i,
    input  logic         fill_i,
    input  logic [31:0]  fill_inst_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] pending_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [CW-1:0] head_q, fill_q, tail_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            fill_q <= '0;
            tail_q <= '0;
        end else if (flush_i) begin
            head_q <= '0;
            fill_q <= '0;
            tail_q <= '0;
        end else begin
            if (alloc_i) tail_q <= tail_q + CW'(1);
            if (fill_i)  fill_q <= fill_q + CW'(1);
            if (pop_i)   head_q <= head_q + CW'(1);
        end
    end

    // Entry storage needs no reset: an entry is only visible once allocated and filled.
    always_ff @(posedge clk_i) begin
        if (!flush_i && alloc_i) begin
            mem_q[tail_q[AW-1:0]] <= '{pc: alloc_pc_i, inst: 32'h0, filled: 1'b0};
        end
        if (!flush_i && fill_i) begin
            mem_q[fill_q[AW-1:0]].inst   <= fill_inst_i;
            mem_q[fill_q[AW-1:0]].filled <= 1'b1;
        end
    end

    assign head_o    = mem_q[head_q[AW-1:0]];
    assign count_o   = tail_q - head_q;
    assign pending_o = tail_q - fill_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, issues in-order word requests, drops stale responses
// after a redirect and presents returned instructions to decode. Optional macro: FETCH_PERF_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic [31:0] stall_cnt_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = CW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [DW-1:0] drop_q, drop_d;
    logic [DW-1:0] alloc_cnt, drop_sum;
    logic [CW-1:0] count, pending;
    fetch_entry_t  head;
    logic          head_valid, grant, fill, discard, pop;
    logic          unused_rpc_bits;

    assign unused_rpc_bits = ^redirect_pc_i[1:0];

    // Dropped in-flight words keep their credit until they come back.
    assign alloc_cnt  = DW'(count) + drop_q;
    assign imem_req_o = !rst_i && !redirect_i && (alloc_cnt < DW'(DEPTH));
    assign imem_addr_o = pc_q;
    assign grant      = imem_req_o && imem_gnt_i;
    assign discard    = imem_rvalid_i && (drop_q != '0);
    assign fill       = imem_rvalid_i && (drop_q == '0) && (pending != '0) && !redirect_i;
    assign head_valid = (count != '0) && head.filled;
    assign pop        = head_valid && inst_ready_i && !redirect_i;

    assign inst_valid_o = head_valid;
    assign inst_o       = head_valid ? head.inst : 32'h0;
    assign inst_pc_o    = head_valid ? head.pc   : 32'h0;

    // Everything still owed by memory at redirect becomes a drop, less any word returning now.
    assign drop_sum = drop_q + DW'(pending) + DW'(imem_gnt_i);

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_i) begin
            pc_d   = {redirect_pc_i[31:2], 2'b00};
            drop_d = (imem_rvalid_i && drop_sum != '0) ? drop_sum - DW'(1) : drop_sum;
        end else begin
            if (grant)   pc_d   = pc_q + 32'(INSTR_BYTES);
            if (discard) drop_d = drop_q - DW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (redirect_i),
        .alloc_i     (grant),
        .alloc_pc_i  (pc_q),
        .fill_i      (fill),
        .fill_inst_i (imem_rdata_i),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .pending_o   (pending)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (inst_ready_i && !head_valid && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=2): streaming, backpressure, redirects, grant stall,
// async reset and the decode-starve counter (expected values depend on FETCH_PERF_EN).
module tb_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [31:0] stall_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  fetch_queue #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for the next rising edge, drive this cycle's inputs, let outputs settle.
  task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                     input logic rdy, input logic rdr, input logic [31:0] rpc);
    @(posedge clk_i);
    #1;
    imem_gnt_i    = g;
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    inst_ready_i  = rdy;
    redirect_i    = rdr;
    redirect_pc_i = rpc;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic vld, input logic [31:0] inst, input logic [31:0] ipc);
    chk({tag, ".req"},  {31'h0, imem_req_o},   {31'h0, req});
    chk({tag, ".addr"}, imem_addr_o,           addr);
    chk({tag, ".vld"},  {31'h0, inst_valid_o}, {31'h0, vld});
    chk({tag, ".inst"}, inst_o,                inst);
    chk({tag, ".ipc"},  inst_pc_o,             ipc);
  endtask

  initial begin
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; inst_ready_i = 1'b0;
    #2;
    chk_out("rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("rst.stall", stall_cnt_o, 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Streaming: gnt always high, 1-cycle response latency.
    cyc(1, 0, 0, 1, 0, 0);              chk_out("s0", 1, 32'h0,  0, 0, 0);
    cyc(1, 1, dat(32'h0), 1, 0, 0);     chk_out("s1", 1, 32'h4,  0, 0, 0);
    cyc(1, 1, dat(32'h4), 1, 0, 0);     chk_out("s2", 0, 32'h8,  1, dat(32'h0), 32'h0);
    cyc(1, 0, 0, 1, 0, 0);              chk_out("s3", 1, 32'h8,  1, dat(32'h4), 32'h4);
    cyc(1, 1, dat(32'h8), 1, 0, 0);     chk_out("s4", 1, 32'hC,  0, 0, 0);
    cyc(1, 1, dat(32'hC), 1, 0, 0);     chk_out("s5", 0, 32'h10, 1, dat(32'h8), 32'h8);
    cyc(1, 0, 0, 1, 0, 0);              chk_out("s6", 1, 32'h10, 1, dat(32'hC), 32'hC);

    // Backpressure: queue fills at 2, req drops, resumes the cycle after the first pop.
    cyc(1, 1, dat(32'h10), 0, 0, 0);    chk_out("b0", 1, 32'h14, 0, 0, 0);
    cyc(1, 1, dat(32'h14), 0, 0, 0);    chk_out("b1", 0, 32'h18, 1, dat(32'h10), 32'h10);
    cyc(1, 0, 0, 0, 0, 0);              chk_out("b2", 0, 32'h18, 1, dat(32'h10), 32'h10);
    cyc(1, 0, 0, 1, 0, 0);              chk_out("b3", 0, 32'h18, 1, dat(32'h10), 32'h10);
    cyc(1, 0, 0, 1, 0, 0);              chk_out("b4", 1, 32'h18, 1, dat(32'h14), 32'h14);

    // Two in flight, redirect to 0x100: both stale words discarded while holding credit.
    cyc(1, 0, 0, 1, 0, 0);              chk_out("r0", 1, 32'h1C, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h100);        chk_out("r1", 0, 32'h20, 0, 0, 0);
    cyc(0, 1, dat(32'h18), 1, 0, 0);    chk_out("r2", 0, 32'h100, 0, 0, 0);
    cyc(1, 1, dat(32'h1C), 1, 0, 0);    chk_out("r3", 1, 32'h100, 0, 0, 0);
    cyc(0, 1, dat(32'h100), 1, 0, 0);   chk_out("r4", 1, 32'h104, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);              chk_out("r5", 1, 32'h104, 1, dat(32'h100), 32'h100);

    // Redirect in the same cycle as a grant; unaligned target is forced to 0x200.
    cyc(1, 0, 0, 1, 0, 0);              chk_out("g0", 1, 32'h104, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 32'h203);        chk_out("g1", 0, 32'h108, 0, 0, 0);
    cyc(0, 1, dat(32'h104), 1, 0, 0);   chk_out("g2", 0, 32'h200, 0, 0, 0);
    cyc(0, 1, dat(32'h108), 1, 0, 0);   chk_out("g3", 1, 32'h200, 0, 0, 0);

    // Grant held low: address stable, no PC advance, nothing valid.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 0, 0);            chk_out("w", 1, 32'h200, 0, 0, 0);
    end
    cyc(1, 0, 0, 1, 0, 0);              chk_out("w5", 1, 32'h200, 0, 0, 0);
    cyc(0, 1, dat(32'h200), 1, 0, 0);   chk_out("w6", 1, 32'h204, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);              chk_out("w7", 1, 32'h204, 1, dat(32'h200), 32'h200);

    // Asynchronous reset with a request in flight.
    cyc(1, 0, 0, 1, 0, 0);              chk_out("a0", 1, 32'h204, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    #1;
    chk_out("a1", 0, 32'h0, 0, 0, 0);
    chk("a1.stall", stall_cnt_o, 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Decode-starve counter with 3-cycle memory latency.
    cyc(1, 0, 0, 1, 0, 0);              chk_out("p0", 1, 32'h0, 0, 0, 0);
    chk("p0.stall", stall_cnt_o, 32'h0);
    cyc(0, 0, 0, 1, 0, 0);              chk("p1.stall", stall_cnt_o, PERF ? 32'd1 : 32'd0);
    chk("p1.addr", imem_addr_o, 32'h4);
    cyc(0, 0, 0, 1, 0, 0);              chk("p2.stall", stall_cnt_o, PERF ? 32'd2 : 32'd0);
    cyc(0, 1, dat(32'h0), 1, 0, 0);     chk("p3.stall", stall_cnt_o, PERF ? 32'd3 : 32'd0);
    cyc(0, 0, 0, 1, 0, 0);              chk_out("p4", 1, 32'h4, 1, dat(32'h0), 32'h0);
    chk("p4.stall", stall_cnt_o, PERF ? 32'd4 : 32'd0);
    cyc(0, 0, 0, 1, 0, 0);              chk("p5.stall", stall_cnt_o, PERF ? 32'd4 : 32'd0);
    chk("p5.vld", {31'h0, inst_valid_o}, 32'h0);
    cyc(0, 0, 0, 1, 0, 0);              chk("p6.stall", stall_cnt_o, PERF ? 32'd5 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
